// File: rtl/multdiv_pkg.sv
// multdiv_pkg: shared state encoding and iteration constants for the multiply/divide sequencer.
package multdiv_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2, DONE = 2'd3} state_t;
    localparam int MULT_ITERS = 16;
    localparam int DIV_ITERS  = 32;
    localparam int CNT_W      = 6;
endpackage

// File: rtl/multdiv_iter_counter.sv
// iter_counter: up counter with synchronous clear/enable and a terminal-count compare against term_i.
module iter_counter #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] term_i,
    output logic [W-1:0] cnt_o,
    output logic         tc_o
);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = clr_i ? '0 : en_i ? cnt_q + W'(1) : cnt_q;
    always_ff @(posedge clk) begin
        if (!clr_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
    assign cnt_o = cnt_q;
    assign tc_o  = cnt_q == term_i;
endmodule

// File: rtl/multdiv_seq.sv
// multdiv_seq: IDLE/LOAD/RUN/DONE sequencer for the multi-cycle multiply/divide registers.
// Optional MULTDIV_EARLY_TERM_EN lets rem_zero end a multiply early.
module multdiv_seq
    import multdiv_pkg::*;
#(
    parameter int MULT_ITERS = multdiv_pkg::MULT_ITERS,
    parameter int DIV_ITERS  = multdiv_pkg::DIV_ITERS,
    parameter int CNT_W      = multdiv_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             ctrl_mult,
    input  logic             ctrl_div,
    input  logic             divisor_zero,
    input  logic             rem_zero,
    output logic             op_is_div,
    output logic             load_en,
    output logic             step_en,
    output logic [CNT_W-1:0] step_idx,
    output logic             busy,
    output logic             data_ready,
    output logic             data_exception
);
    localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_ITERS - 1);
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_ITERS - 1);
    state_t state_q, state_d;
    logic op_q, op_d, exc_q, exc_d;
    logic start, div_start, zero_div, early, tc, last;
    assign start     = ctrl_mult | ctrl_div;
    assign div_start = ctrl_div & ~ctrl_mult;
    assign zero_div  = div_start & divisor_zero;
`ifdef MULTDIV_EARLY_TERM_EN
    assign early = ~op_q & rem_zero;
`else
    assign early = 1'b0 & rem_zero;
`endif
    assign last = tc | early;
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        exc_d   = exc_q;
        if (start) begin
            state_d = zero_div ? DONE : LOAD;
            op_d    = div_start;
            exc_d   = zero_div;
        end else begin
            state_d = state_q == LOAD ? RUN :
                      state_q == RUN  ? (last ? DONE : RUN) : IDLE;
        end
    end
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state_q <= IDLE;
            op_q    <= 1'b0;
            exc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            exc_q   <= exc_d;
        end
    end
    // Counter holds on the last step so step_idx never wraps past ITERS-1.
    iter_counter #(.W(CNT_W)) u_cnt (
        .clk    (clk),
        .clr_n  (clr_n),
        .clr_i  (start),
        .en_i   (state_q == RUN && !last),
        .term_i (op_q ? DIV_LAST : MULT_LAST),
        .cnt_o  (step_idx),
        .tc_o   (tc)
    );
    assign op_is_div      = op_q;
    assign load_en        = state_q == LOAD;
    assign step_en        = state_q == RUN;
    assign busy           = state_q == LOAD || state_q == RUN;
    assign data_ready     = state_q == DONE;
    assign data_exception = state_q == DONE && exc_q;
endmodule
